// File: rtl/fetch_prefetch_unit.sv
// Instruction prefetch stage: issues in-order word fetches, buffers returned words with
// their PCs in a small FIFO and presents them to the core on a valid/ready port.
module fetch_prefetch_unit #(
  parameter int               WIDTH    = 32,
  parameter int               DEPTH    = 4,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             imem_req_valid,
  input  logic             imem_req_ready,
  output logic [WIDTH-1:0] imem_req_addr,
  input  logic             imem_rsp_valid,
  input  logic [WIDTH-1:0] imem_rsp_data,
  input  logic             redirect,
  input  logic [WIDTH-1:0] redirect_pc,
  output logic             inst_valid,
  input  logic             inst_ready,
  output logic [WIDTH-1:0] inst_data,
  output logic [WIDTH-1:0] inst_pc
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] FULL_LVL = (CW+1)'(DEPTH);

  logic [WIDTH-1:0] fetch_pc;
  logic [WIDTH-1:0] rsp_pc;
  logic [WIDTH-1:0] data_mem [DEPTH];
  logic [WIDTH-1:0] pc_mem   [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [CW-1:0]    fifo_cnt;
  logic [CW-1:0]    outstanding;
  logic [CW-1:0]    drop_cnt;
  logic [CW:0]      credit_used;
  logic [WIDTH-1:0] redirect_aligned;
  logic             req_fire;
  logic             rsp_take;
  logic             push;
  logic             pop;

  // Handshakes: a transfer happens on a rising edge where valid & ready are both high.
  // Once raised, imem_req_valid only drops without a transfer when redirect is asserted.
  // Responses have no ready; they arrive in request order and are always accepted.
  assign credit_used      = {1'b0, fifo_cnt} + {1'b0, outstanding};
  assign imem_req_valid   = rst_n & ~redirect & (credit_used < FULL_LVL);
  assign imem_req_addr    = fetch_pc;
  assign redirect_aligned = {redirect_pc[WIDTH-1:2], 2'b00};

  assign req_fire = imem_req_valid & imem_req_ready;
  assign rsp_take = imem_rsp_valid & (outstanding != '0);
  assign push     = rsp_take & (drop_cnt == '0) & ~redirect;
  assign pop      = inst_valid & inst_ready;

  assign inst_valid = rst_n & (fifo_cnt != '0);
  assign inst_data  = data_mem[rd_ptr];
  assign inst_pc    = pc_mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      fifo_cnt    <= '0;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      outstanding <= outstanding + CW'(req_fire) - CW'(rsp_take);
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (redirect) begin
        fetch_pc <= redirect_aligned;
        rsp_pc   <= redirect_aligned;
        fifo_cnt <= '0;
        wr_ptr   <= rd_ptr + AW'(pop);
        // Everything still in flight after this edge belongs to the abandoned stream.
        drop_cnt <= outstanding - CW'(rsp_take);
      end else begin
        if (req_fire) begin
          fetch_pc <= fetch_pc + WIDTH'(4);
        end
        if (rsp_take) begin
          if (drop_cnt != '0) begin
            drop_cnt <= drop_cnt - CW'(1);
          end else begin
            rsp_pc <= rsp_pc + WIDTH'(4);
          end
        end
        if (push) begin
          wr_ptr <= wr_ptr + AW'(1);
        end
        fifo_cnt <= fifo_cnt + CW'(push) - CW'(pop);
      end
    end
  end

  // Storage needs no reset; entries are only visible once counted in fifo_cnt.
  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[wr_ptr] <= imem_rsp_data;
      pc_mem[wr_ptr]   <= rsp_pc;
    end
  end

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Directed bench for fetch_prefetch_unit with a variable-latency instruction memory model
// whose response data is the fetch address XOR a per-phase key.
module tb_fetch_prefetch_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         imem_req_valid;
  logic         imem_req_ready;
  logic [W-1:0] imem_req_addr;
  logic         imem_rsp_valid;
  logic [W-1:0] imem_rsp_data;
  logic         redirect;
  logic [W-1:0] redirect_pc;
  logic         inst_valid;
  logic         inst_ready;
  logic [W-1:0] inst_data;
  logic [W-1:0] inst_pc;

  always #5 clk = ~clk;

  fetch_prefetch_unit #(
    .WIDTH(W),
    .DEPTH(4),
    .RESET_PC('0)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc)
  );

  typedef struct {
    logic [W-1:0] addr;
    logic [W-1:0] data;
    int           due;
  } mem_req_t;

  mem_req_t     mem_q[$];
  logic [W-1:0] req_log[$];
  logic [W-1:0] pop_pc_log[$];
  logic [W-1:0] pop_data_log[$];
  int           cyc = 0;
  int           lat = 1;
  logic [W-1:0] data_key = 32'h5A5A_0000;
  int           checks = 0;
  int           failures = 0;

  task automatic check_eq(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", tag, act, exp);
    end
  endtask

  function automatic logic [W-1:0] q_at(input logic [W-1:0] q[$], input int i);
    if (i < q.size()) return q[i];
    return 'x;
  endfunction

  // Memory model: response for a request accepted at edge e is presented for edge e+lat.
  // Handshakes are sampled 1 time unit before each rising edge.
  always begin
    @(negedge clk);
    if (mem_q.size() != 0 && mem_q[0].due <= cyc + 1) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_q[0].data;
    end else begin
      imem_rsp_valid = 1'b0;
    end
    #4;
    if (imem_rsp_valid && mem_q.size() != 0) void'(mem_q.pop_front());
    if (imem_req_valid && imem_req_ready) begin
      mem_q.push_back('{addr: imem_req_addr, data: imem_req_addr ^ data_key, due: cyc + 1 + lat});
      req_log.push_back(imem_req_addr);
    end
    if (inst_valid && inst_ready) begin
      pop_pc_log.push_back(inst_pc);
      pop_data_log.push_back(inst_data);
    end
    @(posedge clk);
    cyc = cyc + 1;
  end

  task automatic apply_reset(input bit clear_mem);
    @(negedge clk);
    rst_n          = 1'b0;
    redirect       = 1'b0;
    redirect_pc    = '0;
    imem_req_ready = 1'b1;
    inst_ready     = 1'b0;
    if (clear_mem) mem_q.delete();
    req_log.delete();
    pop_pc_log.delete();
    pop_data_log.delete();
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; redirect = 1'b0; redirect_pc = '0;
    imem_req_ready = 1'b1; inst_ready = 1'b0;
    imem_rsp_valid = 1'b0; imem_rsp_data = '0;

    // 1: reset outputs, then back-to-back fetches with latency 1
    apply_reset(1'b1);
    lat = 1;
    inst_ready = 1'b1;
    check_eq("t1_rst_req_valid", W'(imem_req_valid), 32'd0);
    check_eq("t1_rst_inst_valid", W'(inst_valid), 32'd0);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      check_eq($sformatf("t1_req_valid_%0d", k), W'(imem_req_valid), 32'd1);
      check_eq($sformatf("t1_req_addr_%0d", k), imem_req_addr, W'(4 * k));
      if (k >= 2) begin
        check_eq($sformatf("t1_inst_valid_%0d", k), W'(inst_valid), 32'd1);
        check_eq($sformatf("t1_inst_pc_%0d", k), inst_pc, W'(4 * (k - 2)));
        check_eq($sformatf("t1_inst_data_%0d", k), inst_data, W'(4 * (k - 2)) ^ data_key);
      end else begin
        check_eq($sformatf("t1_inst_idle_%0d", k), W'(inst_valid), 32'd0);
      end
    end

    // 2: consumer stalled, credits stop issue at 4; then drain in order
    apply_reset(1'b1);
    lat = 1;
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    check_eq("t2_req_count", W'(req_log.size()), 32'd4);
    for (int i = 0; i < 4; i++) check_eq($sformatf("t2_req_addr_%0d", i), q_at(req_log, i), W'(4 * i));
    check_eq("t2_req_held", W'(imem_req_valid), 32'd0);
    check_eq("t2_head_pc", inst_pc, 32'h0);
    inst_ready = 1'b1;
    repeat (6) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("t2_pop_pc_%0d", i), q_at(pop_pc_log, i), W'(4 * i));
      check_eq($sformatf("t2_pop_data_%0d", i), q_at(pop_data_log, i), W'(4 * i) ^ data_key);
    end
    check_eq("t2_next_req", q_at(req_log, 4), 32'h10);

    // 3: latency 4, three in flight, redirect to 0x100 drops all three
    apply_reset(1'b1);
    lat = 4;
    inst_ready = 1'b1;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("t3_in_flight", W'(req_log.size()), 32'd3);
    redirect = 1'b1;
    redirect_pc = 32'h100;
    #1;
    check_eq("t3_redir_req_valid", W'(imem_req_valid), 32'd0);
    @(negedge clk);
    redirect = 1'b0;
    for (int k = 4; k <= 8; k++) begin
      if (k > 4) @(negedge clk);
      check_eq($sformatf("t3_idle_%0d", k), W'(inst_valid), 32'd0);
    end
    @(negedge clk);
    check_eq("t3_first_valid", W'(inst_valid), 32'd1);
    check_eq("t3_first_pc", inst_pc, 32'h100);
    check_eq("t3_first_data", inst_data, 32'h100 ^ data_key);
    repeat (6) @(negedge clk);
    check_eq("t3_req_after_redir", q_at(req_log, 3), 32'h100);
    check_eq("t3_pop_pc_0", q_at(pop_pc_log, 0), 32'h100);
    check_eq("t3_pop_pc_1", q_at(pop_pc_log, 1), 32'h104);
    check_eq("t3_pop_data_1", q_at(pop_data_log, 1), 32'h104 ^ data_key);

    // 4: redirect together with an arriving response and a pop (latency 2)
    apply_reset(1'b1);
    lat = 2;
    inst_ready = 1'b1;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("t4_pre_head_pc", inst_pc, 32'h0);
    check_eq("t4_pre_rsp_valid", W'(imem_rsp_valid), 32'd1);
    redirect = 1'b1;
    redirect_pc = 32'h200;
    @(negedge clk);
    redirect = 1'b0;
    #1;
    check_eq("t4_fifo_flushed", W'(inst_valid), 32'd0);
    check_eq("t4_pop_once", W'(pop_pc_log.size()), 32'd1);
    check_eq("t4_req_addr", imem_req_addr, 32'h200);
    repeat (6) @(negedge clk);
    check_eq("t4_pop_pc_0", q_at(pop_pc_log, 0), 32'h0);
    check_eq("t4_pop_data_0", q_at(pop_data_log, 0), 32'h0 ^ data_key);
    check_eq("t4_pop_pc_1", q_at(pop_pc_log, 1), 32'h200);
    check_eq("t4_pop_data_1", q_at(pop_data_log, 1), 32'h200 ^ data_key);
    check_eq("t4_pop_pc_2", q_at(pop_pc_log, 2), 32'h204);

    // 5: unaligned redirect near the top of the address space wraps to zero
    apply_reset(1'b1);
    lat = 1;
    inst_ready = 1'b1;
    rst_n = 1'b1;
    redirect = 1'b1;
    redirect_pc = 32'hFFFF_FFFE;
    #1;
    check_eq("t5_redir_req_valid", W'(imem_req_valid), 32'd0);
    @(negedge clk);
    redirect = 1'b0;
    #1;
    check_eq("t5_req_addr", imem_req_addr, 32'hFFFF_FFFC);
    repeat (6) @(negedge clk);
    check_eq("t5_req_0", q_at(req_log, 0), 32'hFFFF_FFFC);
    check_eq("t5_req_1", q_at(req_log, 1), 32'h0);
    check_eq("t5_pop_pc_0", q_at(pop_pc_log, 0), 32'hFFFF_FFFC);
    check_eq("t5_pop_pc_1", q_at(pop_pc_log, 1), 32'h0);
    check_eq("t5_pop_data_1", q_at(pop_data_log, 1), 32'h0 ^ data_key);

    // 6: reset with two requests in flight; their late responses must be ignored
    apply_reset(1'b1);
    lat = 4;
    data_key = 32'hDEAD_0000;
    inst_ready = 1'b1;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("t6_in_flight", W'(req_log.size()), 32'd2);
    rst_n = 1'b0;
    imem_req_ready = 1'b0;
    #1;
    check_eq("t6_rst_req_valid", W'(imem_req_valid), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    data_key = 32'h1234_0000;
    lat = 1;
    #1;
    check_eq("t6_req_valid", W'(imem_req_valid), 32'd1);
    check_eq("t6_req_addr", imem_req_addr, 32'h0);
    for (int k = 4; k <= 7; k++) begin
      if (k > 4) @(negedge clk);
      if (k == 6) imem_req_ready = 1'b1;
      check_eq($sformatf("t6_idle_%0d", k), W'(inst_valid), 32'd0);
    end
    @(negedge clk);
    check_eq("t6_first_valid", W'(inst_valid), 32'd1);
    check_eq("t6_first_pc", inst_pc, 32'h0);
    check_eq("t6_first_data", inst_data, 32'h1234_0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
